// File: rtl/mux2_pkg.sv
// Shared defaults and the select encoding for the mux2_sel slice.
package mux2_pkg;

  localparam int MUX2_WIDTH = 1;
  localparam int MUX2_CNT_W = 8;

  typedef enum logic {
    SEL_IN0 = 1'b0,
    SEL_IN1 = 1'b1
  } sel_t;

endpackage

// File: rtl/mux2_if.sv
// Select/data bundle of mux2_sel. The master drives the select and the data inputs.
// The slave returns the selected data and the toggle count.
interface mux2_if import mux2_pkg::*; #(
  parameter int WIDTH = MUX2_WIDTH,
  parameter int CNT_W = MUX2_CNT_W
) ();

  logic             io_sel;
  logic [WIDTH-1:0] io_in0;
  logic [WIDTH-1:0] io_in1;
  logic [WIDTH-1:0] io_out;
  logic [CNT_W-1:0] io_sw_cnt;

  modport master (
    output io_sel,
    output io_in0,
    output io_in1,
    input  io_out,
    input  io_sw_cnt
  );

  modport slave (
    input  io_sel,
    input  io_in0,
    input  io_in1,
    output io_out,
    output io_sw_cnt
  );

endinterface

// File: rtl/mux2_cell.sv
// Combinational WIDTH-bit 2:1 select, the leaf cell of mux2_sel.
module mux2_cell import mux2_pkg::*; #(
  parameter int WIDTH = MUX2_WIDTH
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  assign out = (sel == SEL_IN1) ? in1 : in0;

endmodule

// File: rtl/mux2_sel.sv
// 2:1 data selector with a saturating select-toggle counter.
// Defining MUX2_OUT_REG_EN adds a one-cycle output register that clears on reset.
module mux2_sel import mux2_pkg::*; #(
  parameter int WIDTH = MUX2_WIDTH,
  parameter int CNT_W = MUX2_CNT_W
) (
  input logic   clock,
  input logic   reset,
  mux2_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sel_data;
  logic             sel_q;
  logic [CNT_W-1:0] sw_cnt;

  mux2_cell #(.WIDTH(WIDTH)) u_cell (
    .sel (sel_t'(bus.io_sel)),
    .in0 (bus.io_in0),
    .in1 (bus.io_in1),
    .out (sel_data)
  );

`ifdef MUX2_OUT_REG_EN
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= sel_data;
    end
  end

  assign bus.io_out = out_q;
`else
  assign bus.io_out = sel_data;
`endif

  // sel_q clears on reset, so the first io_sel==1 after reset counts as a toggle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q  <= 1'b0;
      sw_cnt <= '0;
    end else begin
      sel_q <= bus.io_sel;
      if ((bus.io_sel != sel_q) && (sw_cnt != CNT_MAX)) begin
        sw_cnt <= sw_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.io_sw_cnt = sw_cnt;

endmodule

// File: tb/tb_mux2_sel.sv
// Scoreboard bench for mux2_sel. Two instances are used: WIDTH=1/CNT_W=2 and WIDTH=8/CNT_W=8.
// A queue-based monitor compares their outputs against a behavioural model.
module tb_mux2_sel;
  import mux2_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mux2_if #(.WIDTH(1), .CNT_W(2)) bus_a ();
  mux2_if #(.WIDTH(8), .CNT_W(8)) bus_b ();

  mux2_sel #(.WIDTH(1), .CNT_W(2)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  mux2_sel #(.WIDTH(8), .CNT_W(8)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  typedef struct {
    string      tag;
    logic [0:0] out_a;
    logic [1:0] cnt_a;
    logic [7:0] out_b;
    logic [7:0] cnt_b;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: the previous select, the toggle count and the registered output of each instance.
  int m_prev_a, m_cnt_a, m_reg_a;
  int m_prev_b, m_cnt_b, m_reg_b;

  // Apply the clock edge that has just passed, using the inputs that were present at that edge.
  task automatic model_edge();
    if (reset) begin
      m_prev_a = 0; m_cnt_a = 0; m_reg_a = 0;
      m_prev_b = 0; m_cnt_b = 0; m_reg_b = 0;
    end else begin
      if (int'(bus_a.io_sel) != m_prev_a) m_cnt_a = (m_cnt_a < 3) ? m_cnt_a + 1 : 3;
      if (int'(bus_b.io_sel) != m_prev_b) m_cnt_b = (m_cnt_b < 255) ? m_cnt_b + 1 : 255;
      m_prev_a = int'(bus_a.io_sel);
      m_prev_b = int'(bus_b.io_sel);
      m_reg_a  = bus_a.io_sel ? int'(bus_a.io_in1) : int'(bus_a.io_in0);
      m_reg_b  = bus_b.io_sel ? int'(bus_b.io_in1) : int'(bus_b.io_in0);
    end
  endtask

  task automatic cycle(input string tag, input bit rst,
                       input bit sa, input bit ia0, input bit ia1,
                       input bit sb, input logic [7:0] ib0, input logic [7:0] ib1);
    exp_t e;
    @(posedge clock);
    #1;
    model_edge();
    reset        = rst;
    bus_a.io_sel = sa;  bus_a.io_in0 = ia0; bus_a.io_in1 = ia1;
    bus_b.io_sel = sb;  bus_b.io_in0 = ib0; bus_b.io_in1 = ib1;
    e.tag = tag;
`ifdef MUX2_OUT_REG_EN
    e.out_a = 1'(m_reg_a);
    e.out_b = 8'(m_reg_b);
`else
    e.out_a = sa ? ia1 : ia0;
    e.out_b = sb ? ib1 : ib0;
`endif
    e.cnt_a = 2'(m_cnt_a);
    e.cnt_b = 8'(m_cnt_b);
    sb_q.push_back(e);
  endtask

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, ".out_a"}, 8'(bus_a.io_out),    8'(e.out_a));
      chk({e.tag, ".cnt_a"}, 8'(bus_a.io_sw_cnt), 8'(e.cnt_a));
      chk({e.tag, ".out_b"}, bus_b.io_out,        e.out_b);
      chk({e.tag, ".cnt_b"}, bus_b.io_sw_cnt,     e.cnt_b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sb_seq[6];
    bit rst;
    sb_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    bus_a.io_sel = 1'b0; bus_a.io_in0 = 1'b0; bus_a.io_in1 = 1'b0;
    bus_b.io_sel = 1'b0; bus_b.io_in0 = 8'h00; bus_b.io_in1 = 8'h00;

    cycle("rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22);
    cycle("rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 8'h22);

    for (int i = 0; i < 8; i++) begin
      bit [2:0] v;
      v = 3'(i);
      cycle("exh", 1'b0, v[2], v[1], v[0], 1'b0, 8'hA5, 8'h3C);
    end

    cycle("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C);

    // Instance b walks the 0,1,0,1,1 sequence and then changes in0 while sel=1.
    // Instance a toggles sel on every cycle to drive its 2-bit counter into saturation.
    for (int k = 0; k < 6; k++) begin
      cycle((k == 5) ? "chg_in0" : "tgl", 1'b0, (k % 2) == 0, 1'b0, 1'b1,
            sb_seq[k], (k == 5) ? 8'h5A : 8'hA5, 8'h3C);
    end
    cycle("sat", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h3C);

    cycle("rst2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
    cycle("post", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
    cycle("post", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);

    for (int r = 0; r < 300; r++) begin
      rst = ($urandom_range(0, 15) == 0);
      cycle(rst ? "rnd_rst" : "rnd", rst,
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (3) @(negedge clock);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
